// File: rtl/seq_dec_param.sv
// Serial pattern detector: matches a qualified bit stream against a runtime-loadable
// PAT_LEN-bit pattern (MSB first), strobes on each match and keeps a saturating match count.
module seq_dec_param #(
    parameter int                 PAT_LEN     = 4,
    parameter logic [PAT_LEN-1:0] DEF_PATTERN = 4'b1101,
    parameter int                 CNT_W       = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               inp,
    input  logic               inp_valid,
    input  logic               overlap,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
    input  logic               cnt_clr,
    output logic               outp,
    output logic [CNT_W-1:0]   match_count,
    output logic [PAT_LEN-1:0] pattern
);

    localparam int                FILL_W    = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [PAT_LEN-1:0] r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic [PAT_LEN-1:0] r_pattern;
    logic               r_outp;
    logic [CNT_W-1:0]   r_count;

    logic               w_accept;
    logic [PAT_LEN-1:0] w_shifted;
    logic               w_match;

    // A load cycle swallows any simultaneous data bit, so it never counts as accepted.
    assign w_accept  = inp_valid & ~pat_load;
    assign w_shifted = {r_hist[PAT_LEN-2:0], inp};
    assign w_match   = w_accept && (w_shifted == r_pattern) && (r_fill >= FILL_ARM);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hist    <= '0;
            r_fill    <= '0;
            r_pattern <= DEF_PATTERN;
            r_outp    <= 1'b0;
        end else if (pat_load) begin
            r_pattern <= pat_in;
            r_fill    <= '0;
            r_outp    <= 1'b0;
        end else if (w_accept) begin
            r_hist <= w_shifted;
            r_outp <= w_match;
            // Non-overlapping mode forgets the history so the next match needs fresh bits.
            if (w_match && !overlap) begin
                r_fill <= '0;
            end else if (r_fill != FILL_FULL) begin
                r_fill <= r_fill + FILL_W'(1);
            end
        end else begin
            r_outp <= 1'b0;
        end
    end

    // Clear wins over the old count but a coincident match still counts as the first one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (cnt_clr) begin
            r_count <= w_match ? CNT_W'(1) : '0;
        end else if (w_match && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign outp        = r_outp;
    assign match_count = r_count;
    assign pattern     = r_pattern;

endmodule
